// File: rtl/word_serializer.sv
// MSB-first parallel-to-serial converter that streams WIDTH-bit frames back-to-back on encbit.
// Optional even-parity trailer bit per frame when WORD_SERIALIZER_PARITY_EN is defined.
module word_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             encbit,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    // Handshake: a word transfers on any posedge where din_valid && din_ready.
    // din_ready depends only on state and counter; the source must hold din and
    // din_valid stable until the transfer happens.

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int CW = (LAST + 1 > 1) ? $clog2(LAST + 1) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             enc_q, enc_n;
    logic             last_bit;
    logic             xfer;

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] DATA_LAST_C = CW'(WIDTH - 1);
    logic par_q, par_n;
`endif

    assign last_bit    = (state == SHIFT) && (cnt == LAST_C);
    assign din_ready   = (state == IDLE) || last_bit;
    assign xfer        = din_valid && din_ready;
    assign encbit      = enc_q;
    assign busy        = (state == SHIFT);
    assign bit_valid   = (state == SHIFT);
    assign frame_start = (state == SHIFT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            enc_q <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sreg  <= sreg_n;
            enc_q <= enc_n;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

    // The MSB goes straight to encbit on load; sreg holds the bits still to come.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        enc_n   = enc_q;
`ifdef WORD_SERIALIZER_PARITY_EN
        par_n   = par_q;
`endif
        if (xfer) begin
            state_n = SHIFT;
            cnt_n   = '0;
            enc_n   = din[WIDTH-1];
            sreg_n  = {din[WIDTH-2:0], 1'b0};
`ifdef WORD_SERIALIZER_PARITY_EN
            par_n   = ^din;
`endif
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state_n = IDLE;
                cnt_n   = '0;
                enc_n   = 1'b0;
                sreg_n  = '0;
            end else begin
                cnt_n  = cnt + CW'(1);
                sreg_n = {sreg[WIDTH-2:0], 1'b0};
`ifdef WORD_SERIALIZER_PARITY_EN
                if (cnt == DATA_LAST_C) enc_n = par_q;
                else                    enc_n = sreg[WIDTH-1];
`else
                enc_n  = sreg[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: bit-queue reference model plus a
// receive-side deserializer that rebuilds each frame and checks it in order.
module tb_word_serializer;
  localparam int WIDTH = 16;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din_valid = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic din_ready, encbit, bit_valid, frame_start, busy;

  word_serializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .encbit(encbit), .bit_valid(bit_valid),
    .frame_start(frame_start), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: the bits still owed on the line, head = bit shown this cycle
  logic exp_q[$];
  logic [WIDTH-1:0] exp_words[$];
  bit started = 1'b0;
  bit last_xfer = 1'b0;
  bit m_rdy;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      exp_q.delete();
      exp_words.delete();
      last_xfer = 1'b0;
    end else begin
      m_rdy = (exp_q.size() <= 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      last_xfer = din_valid && m_rdy;
      if (last_xfer) begin
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(din[i]);
`ifdef WORD_SERIALIZER_PARITY_EN
        exp_q.push_back(^din);
`endif
        exp_words.push_back(din);
      end
    end
  end

  // scoreboard: per-cycle output compare plus frame reassembly
  logic [FLEN-1:0] rx_sh = '0;
  int rx_n = 0;
  logic [WIDTH-1:0] rx_w;

  always @(negedge clk) begin
    if (started) begin
      check("encbit", 32'(encbit), 32'((exp_q.size() > 0) ? exp_q[0] : 1'b0));
      check("bit_valid", 32'(bit_valid), 32'(exp_q.size() > 0));
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      check("frame_start", 32'(frame_start), 32'(exp_q.size() == FLEN));
      check("din_ready", 32'(din_ready), 32'(exp_q.size() <= 1));
      if (reset) begin
        rx_n = 0;
      end else if (bit_valid === 1'b1) begin
        rx_sh = {rx_sh[FLEN-2:0], encbit};
        rx_n++;
        if (rx_n == FLEN) begin
          rx_n = 0;
          if (exp_words.size() == 0) begin
            check("rx_extra_frame", 32'(1), 32'(0));
          end else begin
            rx_w = exp_words.pop_front();
            check("rx_word", 32'(rx_sh[FLEN-1 -: WIDTH]), 32'(rx_w));
`ifdef WORD_SERIALIZER_PARITY_EN
            check("rx_parity", 32'(rx_sh[0]), 32'(^rx_w));
`endif
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i <= FLEN + 2; i++) begin
      tick();
      if (last_xfer) return;
    end
    check("send_timeout", 32'(0), 32'(1));
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    din = 'x;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    din_valid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  int gap;

  initial begin
    do_reset(2);
    // single frame, then underrun to idle
    send_word(16'hA5C3);
    idle(FLEN + 4);
    // back-to-back
    send_word(16'hFFFF);
    send_word(16'h0001);
    idle(FLEN + 4);
    // underrun then restart 5 cycles after idle
    send_word(16'h8000);
    idle(FLEN + 5);
    send_word(16'h4001);
    idle(FLEN + 3);
    // reset during bit 7
    send_word(16'hFFFF);
    din_valid = 1'b0;
    repeat (7) tick();
    do_reset(1);
    idle(FLEN + 3);
    // loopback sequence
    send_word(16'h1234);
    send_word(16'h5678);
    send_word(16'h9ABC);
    idle(FLEN + 3);
`ifdef WORD_SERIALIZER_PARITY_EN
    send_word(16'h0007);
    send_word(16'h0003);
    idle(FLEN + 3);
`endif
    // randomized traffic with gaps and occasional mid-frame resets
    repeat (150) begin
      send_word(WIDTH'($urandom));
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, FLEN - 2)) tick();
        do_reset(1);
      end
    end
    idle(FLEN + 3);
    check("rx_pending", 32'(exp_words.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Transmit-side counterpart of the 16-bit bit-stream deserializer in the receive path.
- Accepts parallel words over a valid/ready handshake and shifts each one out MSB-first, one bit per clk, on encbit.
- Consecutive frames stream back-to-back with no gaps, so a free-running 16-bit receiver stays frame-aligned.
- Sits between the word source (encoder/packetizer) and the modulator input.

Parameters:
- WIDTH, 16, bits per frame; counter width is clog2(WIDTH); legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- din  input  WIDTH  parallel word to transmit
- din_valid  input  1  din holds a valid word
- din_ready  output  1  block will accept din this cycle
- encbit  output  1  serial data bit, registered
- bit_valid  output  1  encbit carries frame data this cycle
- frame_start  output  1  high during the cycle encbit carries the first (MSB) bit of a frame
- busy  output  1  high whenever state is SHIFT

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is sampled on posedge clk only, and has priority over all other inputs.
- Reset values: encbit=0, bit_valid=0, frame_start=0, busy=0, state=IDLE, bit counter=0, shift register=0.
  - din_ready=1 in the first cycle after reset deasserts.
- States:
  - IDLE: no frame in progress. din_ready=1. encbit=0, bit_valid=0.
  - SHIFT: frame in progress. The bit counter runs from 0 to WIDTH-1.
- Handshake:
  - A transfer occurs on a posedge where din_valid && din_ready.
  - din is captured into the shift register at that edge.
  - The source holds din and din_valid stable until the transfer occurs.
- Latency:
  - Transfer at edge N puts din[WIDTH-1] on encbit, with bit_valid=1 and frame_start=1, in the cycle after edge N.
  - din[WIDTH-1-k] appears k cycles after that.
  - The frame occupies exactly WIDTH consecutive cycles.
- din_ready = (state==IDLE) || (state==SHIFT && counter==WIDTH-1). It is combinational from state and counter only, never from din_valid.
- IDLE -> SHIFT on a transfer; the counter is set to 0.
- SHIFT, counter<WIDTH-1: shift left one bit, counter+1. din is ignored.
- SHIFT, counter==WIDTH-1 (last bit cycle):
  - If a transfer occurs, load the new word, reset the counter to 0 and stay in SHIFT. The next frame's MSB follows immediately with zero gap, and frame_start pulses again.
  - If no transfer occurs (underrun), go to IDLE. The next cycle shows encbit=0 and bit_valid=0.
- Underrun:
  - Is not an error condition inside the block.
  - The downstream receiver loses alignment, so the source is responsible for sustaining din_valid during continuous transmission.
- Reset mid-frame: the frame is aborted and the remaining bits are discarded. Outputs take reset values in the cycle after the reset edge. No partial frame resumes afterwards.
- din_valid asserted while the block is not ready: no capture, no effect.
- X on din with din_valid=0: must not propagate to encbit.

Optional Feature:
- Macro: WORD_SERIALIZER_PARITY_EN
- Defined:
  - Each frame is WIDTH+1 cycles long: the WIDTH data bits, then one even-parity bit (XOR of all din bits) with bit_valid=1.
  - The counter runs 0..WIDTH.
  - din_ready asserts in the parity cycle instead of at counter==WIDTH-1.
  - Back-to-back loading occurs on the parity cycle.
- Undefined:
  - Frame length is exactly WIDTH.
  - No parity logic or extra counter state is synthesized.

Test Plan:
- Single frame:
  - Stimulus: reset for 2 cycles, then one transfer of din=16'hA5C3.
  - Response: encbit = 1010 0101 1100 0011 over 16 cycles, bit_valid=1 throughout, frame_start only on the first bit.
  - Then IDLE with encbit=0 and bit_valid=0.
- Back-to-back:
  - Stimulus: din_valid held high with 16'hFFFF then 16'h0001.
  - Response: 16 ones immediately followed by 15 zeros and a one, with no gap.
  - din_ready high only on the cycle after reset and on each last-bit cycle.
  - frame_start pulses at cycle 1 and cycle 17.
- Underrun:
  - Stimulus: one transfer of 16'h8000, din_valid low afterwards.
  - Response: bit_valid drops in the cycle after bit 15, busy=0, din_ready=1.
  - A new transfer 5 cycles later starts a frame with frame_start=1.
- Reset mid-frame:
  - Stimulus: transfer of 16'hFFFF, reset asserted during bit 7.
  - Response: next cycle encbit=0, bit_valid=0, busy=0.
  - No remaining ones are emitted after reset releases.
- Loopback:
  - Stimulus: serializer output drives the 16-bit deserializer, with both reset together, and words 16'h1234, 16'h5678, 16'h9ABC are sent back-to-back.
  - Response: each word appears on the deserializer's parallel output once per 16 cycles, in order.
- Parity (macro defined):
  - Stimulus: din=16'h0007, then 16'h0003.
  - Response: 17-cycle frames with parity bits 1 then 0.
  - din_ready asserts only on the parity cycles.
